// File: rtl/puf_response_collector.sv
// Purpose : drives an arbiter PUF one race at a time and assembles RESP_BITS race results into a response word.
// Latency : each race takes at least CLR_CYCLES+2 cycles plus 2 synchronizer cycles; the full word is ready RESP_BITS races after start.
// Backpr. : no backpressure; start is taken only in IDLE, and resp_valid holds until the next accepted start.
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : request one full response (sampled only in IDLE)
//   arb_done, arb_out  : asynchronous race-complete level and winner bit from the arbiter
//   arb_reset          : active-high clear to the arbiter and upstream race counters
//   chal_idx           : index of the race in progress (challenge select)
//   response           : collected bits, bit i = result of race i
//   resp_valid         : response complete
//   busy               : high whenever the collector is not idle
//   timeout_err        : sticky, at least one race of the current response timed out
module puf_response_collector #(
  parameter int RESP_BITS  = 16,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  localparam int IDX_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic                 arb_reset,
  output logic [IDX_W-1:0]     chal_idx,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CLR_LIM  = CNT_W'(CLR_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic                   valid_q, valid_d;
  logic                   terr_q, terr_d;
  logic                   cap_q, cap_d;
  logic                   done_s1_q, done_s1_d;
  logic                   done_s_q, done_s_d;
  logic                   out_s1_q, out_s1_d;
  logic                   out_s_q, out_s_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Counter saturates instead of wrapping; it only matters up to TIMEOUT anyway.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // State register: every flop in the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      resp_q    <= '0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      cap_q     <= 1'b0;
      done_s1_q <= 1'b0;
      done_s_q  <= 1'b0;
      out_s1_q  <= 1'b0;
      out_s_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      resp_q    <= resp_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
      cap_q     <= cap_d;
      done_s1_q <= done_s1_d;
      done_s_q  <= done_s_d;
      out_s1_q  <= out_s1_d;
      out_s_q   <= out_s_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    resp_d    = resp_q;
    valid_d   = valid_q;
    terr_d    = terr_q;
    cap_d     = cap_q;
    // Two-stage synchronizers; only the second stage feeds the FSM.
    done_s1_d = arb_done;
    done_s_d  = done_s1_q;
    out_s1_d  = arb_out;
    out_s_d   = out_s1_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          idx_d   = '0;
          resp_d  = '0;
          valid_d = 1'b0;
          terr_d  = 1'b0;
        end
      end

      ST_CLEAR: begin
        cnt_d = cnt_inc;
        // A done level that never drops (stuck arbiter) keeps us here until the timeout.
        if (cnt_inc >= TO_LIM) begin
          state_d = ST_CAPTURE;
          cap_d   = 1'b0;
          terr_d  = 1'b1;
        end else if (cnt_inc >= CLR_LIM && !done_s_q) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A result arriving on the timeout cycle still counts as a real result.
        if (done_s_q) begin
          state_d = ST_CAPTURE;
          cap_d   = out_s_q;
        end else if (cnt_inc >= TO_LIM) begin
          state_d = ST_CAPTURE;
          cap_d   = 1'b0;
          terr_d  = 1'b1;
        end
      end

      ST_CAPTURE: begin
        resp_d[idx_q] = cap_q;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end

      ST_DONE: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. arb_reset also follows reset_n directly so the arbiter is held
  // cleared during reset regardless of clock activity.
  always_comb begin
    arb_reset = 1'b1;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE:    busy      = 1'b0;
      ST_WAIT:    arb_reset = 1'b0;
      default:    arb_reset = 1'b1;
    endcase
    if (!reset_n) begin
      arb_reset = 1'b1;
    end
  end

  assign chal_idx    = idx_q;
  assign response    = resp_q;
  assign resp_valid  = valid_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Purpose : randomized scoreboard bench for puf_response_collector with a behavioural arbiter model.
// Latency : expected words are queued at start; a monitor compares on each resp_valid rise.
// Backpr. : none; all waits are bounded by cycle budgets.
module tb_puf_response_collector;
  localparam int RB  = 16;
  localparam int CLR = 2;
  localparam int TO  = 255;
  // Largest arb_done delay (cycles after arb_reset falls) still seen in time:
  // CLEAR+WAIT may last TO cycles, CLR of them in CLEAR, and the level needs
  // two synchronizer stages before the FSM can act on it.
  localparam int LAST_OK = TO - CLR - 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          arb_done = 1'b0;
  logic          arb_out = 1'b0;
  logic          arb_reset;
  logic [3:0]    chal_idx;
  logic [RB-1:0] response;
  logic          resp_valid;
  logic          busy;
  logic          timeout_err;

  puf_response_collector #(.RESP_BITS(RB), .CLR_CYCLES(CLR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .arb_done(arb_done), .arb_out(arb_out),
    .arb_reset(arb_reset), .chal_idx(chal_idx), .response(response), .resp_valid(resp_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [RB-1:0] resp;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  // Arbiter model configuration: per-race delay (0 = never answers), winner pattern, stuck-done mode.
  int          delay_tab[RB];
  logic [RB-1:0] pat;
  bit          stuck = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a race yields its pattern bit if the arbiter answers in time, else 0 plus an error.
  function automatic exp_t model();
    exp_t e;
    e.resp = '0;
    e.err  = 1'b0;
    for (int i = 0; i < RB; i++) begin
      if (stuck || delay_tab[i] == 0 || delay_tab[i] > LAST_OK) e.err = 1'b1;
      else e.resp[i] = pat[i];
    end
    return e;
  endfunction

  // Arbiter model: clears while arb_reset is high, answers delay_tab[race] cycles after it falls.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (stuck) begin
        arb_done = 1'b1;
      end else if (arb_reset) begin
        arb_done = 1'b0;
        wcnt = 0;
      end else begin
        wcnt++;
        if (delay_tab[chal_idx] != 0 && wcnt >= delay_tab[chal_idx]) arb_done = 1'b1;
      end
      arb_out = pat[chal_idx];
    end
  end

  // Monitor: compare each completed response against the oldest expectation.
  initial begin
    logic rv_prev;
    exp_t e;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid && !rv_prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got response %0h expected no response", response);
        end else begin
          e = sb_q.pop_front();
          chk("response", 32'(response), 32'(e.resp));
          chk("timeout_err", 32'(timeout_err), 32'(e.err));
        end
      end
      rv_prev = resp_valid;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_chal_idx"}, 32'(chal_idx), 32'd0);
    chk({tag, "_response"}, 32'(response), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_arb_reset"}, 32'(arb_reset), 32'd1);
  endtask

  // One response: queue expectation, start, check start side effects, then wait for completion.
  task automatic run(input int abort_at, input int probe, input bit poke,
                     output int pulses, output int probe_cyc);
    exp_t e;
    logic ar_prev;
    bit   poked3, pend, fin;
    e = model();
    sb_q.push_back(e);
    pulses = 0;
    probe_cyc = 0;
    poked3 = 0;
    pend = 0;
    fin = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_clears_valid", 32'(resp_valid), 32'd0);
    chk("start_clears_resp", 32'(response), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    ar_prev = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (busy && arb_reset && !ar_prev) pulses++;
      ar_prev = arb_reset;
      if (busy && chal_idx == 4'(probe)) probe_cyc++;
      if (pend) begin
        chk("busy_start_ignored_idx", 32'(chal_idx), 32'd3);
        chk("busy_start_ignored_busy", 32'(busy), 32'd1);
        pend = 0;
      end
      start = 1'b0;
      if (poke && busy && chal_idx == 4'd3 && !poked3) begin
        start = 1'b1;
        poked3 = 1;
        pend = 1;
      end
      if (poke && busy && chal_idx == 4'(RB - 1)) start = 1'b1;
      if (abort_at >= 0 && busy && chal_idx == 4'(abort_at)) begin
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        void'(sb_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (!busy && resp_valid) begin
        fin = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got busy=%0d resp_valid=%0d expected completion", busy, resp_valid);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected summary");
    $fatal(1);
  end

  initial begin
    int pulses, pc;
    for (int i = 0; i < RB; i++) delay_tab[i] = 3;
    pat = '0;

    // Reset values, observed while reset is held with no clock edge needed.
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Nominal response.
    pat = 16'hA5C3;
    run(-1, 99, 0, pulses, pc);
    chk("arb_reset_pulses", 32'(pulses), 32'd16);

    // Race 5 never answers: exactly TO cycles in CLEAR+WAIT plus one CAPTURE cycle.
    pat = 16'hA5E3;
    delay_tab[5] = 0;
    run(-1, 5, 0, pulses, pc);
    chk("race5_cycles", 32'(pc), 32'(TO + 1));
    delay_tab[5] = 3;

    // arb_done stuck high: every race times out in CLEAR.
    stuck = 1;
    pat = 16'($urandom);
    run(-1, 99, 0, pulses, pc);
    stuck = 0;

    // start while busy (race 3 and through DONE) is ignored.
    pat = 16'($urandom);
    run(-1, 99, 1, pulses, pc);
    repeat (3) @(negedge clk);
    chk("valid_held", 32'(resp_valid), 32'd1);
    chk("idle_after_done", 32'(busy), 32'd0);

    // Reset during race 9 discards the partial word; next response is complete.
    pat = 16'($urandom);
    run(9, 99, 0, pulses, pc);
    pat = 16'($urandom);
    run(-1, 99, 0, pulses, pc);

    // Done arriving on the timeout cycle wins; one cycle later it is a timeout.
    pat = 16'($urandom) | 16'h0080;
    delay_tab[7] = LAST_OK;
    run(-1, 99, 0, pulses, pc);
    delay_tab[7] = LAST_OK + 1;
    run(-1, 99, 0, pulses, pc);
    delay_tab[7] = 3;

    // Random patterns and random per-race delays, occasionally a silent arbiter.
    for (int r = 0; r < 4; r++) begin
      pat = 16'($urandom);
      for (int i = 0; i < RB; i++) begin
        delay_tab[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      end
      run(-1, 99, 0, pulses, pc);
    end

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 Parameter RESP_BITS, default 16: number of arbiter races per response word; SHALL be a power of two, 2..64.
REQ-002 Parameter CLR_CYCLES, default 2: minimum arb_reset assertion per race, 1..15.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent in CLEAR or WAIT per race, 4..65535.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset; synchronous deassertion is the integrator's responsibility.
REQ-006 start  input  1  request one full response; sampled only in IDLE.
REQ-007 arb_done  input  1  race-complete level from the race arbiter; asynchronous to clk.
REQ-008 arb_out  input  1  race winner bit from the race arbiter; asynchronous to clk; valid while arb_done=1.
REQ-009 arb_reset  output  1  active-high clear to the arbiter and upstream race counters.
REQ-010 chal_idx  output  log2(RESP_BITS)  index of the race in progress; also the challenge-select index.
REQ-011 response  output  RESP_BITS  collected bits; bit i = result of race i.
REQ-012 resp_valid  output  1  response complete; held until the next accepted start.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  sticky: at least one race in the current response timed out.

Function
REQ-015 arb_done and arb_out SHALL each pass through a 2-flop synchronizer (done_s, out_s); the FSM SHALL use only the synchronized copies.
REQ-016 FSM states: IDLE, CLEAR, WAIT, CAPTURE, DONE.
REQ-017 IDLE: start=1 -> CLEAR; on that edge response<=0, chal_idx<=0, resp_valid<=0, timeout_err<=0.
REQ-018 start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-019 CLEAR: arb_reset=1; the cycle counter increments each cycle; exit to WAIT when counter>=CLR_CYCLES and done_s=0.
REQ-020 WAIT: arb_reset=0; the counter continues from CLEAR without reset; done_s=1 -> CAPTURE with captured bit = out_s.
REQ-021 Timeout: counter reaching TIMEOUT in CLEAR or WAIT -> CAPTURE with captured bit forced 0; timeout_err<=1.
REQ-022 The counter SHALL be cleared on every entry to CLEAR and SHALL NOT wrap.
REQ-023 CAPTURE (one cycle): response[chal_idx]<=captured bit; arb_reset=1.
REQ-024 CAPTURE exit: chal_idx=RESP_BITS-1 -> DONE; otherwise chal_idx<=chal_idx+1 and -> CLEAR.
REQ-025 DONE (one cycle): resp_valid<=1; -> IDLE; chal_idx holds RESP_BITS-1.
REQ-026 Bits already captured SHALL NOT be modified until the next accepted start.
REQ-027 done_s=1 and timeout on the same WAIT cycle: done_s wins, and timeout_err is not set for that race.
REQ-028 Minimum race cycle time: CLR_CYCLES + 2 cycles (CLEAR + 1 WAIT + CAPTURE), excluding synchronizer delay.

Reset
REQ-029 reset_n=0 SHALL immediately force: state=IDLE, counter=0, chal_idx=0, response=0, resp_valid=0, busy=0, timeout_err=0, synchronizers=0, arb_reset=1.
REQ-030 arb_reset SHALL be driven 1 combinationally while reset_n=0 and in IDLE, so the arbiter stays cleared.
REQ-031 Reset asserted mid-response SHALL discard all partial bits; the first start after reset_n rises SHALL begin at race 0.

Verification
REQ-032 Defaults. Per race, the arbiter model raises arb_done 3 cycles after arb_reset falls, with arb_out = pattern 0xA5C3 bit i -> response=0xA5C3, resp_valid=1, timeout_err=0; arb_reset pulses high 16 times.
REQ-033 Arbiter model never raises arb_done on race 5 -> that race spends exactly 255 cycles in CLEAR+WAIT; response bit 5=0; timeout_err=1; the remaining 15 bits are correct.
REQ-034 arb_done held stuck at 1 -> every race times out in CLEAR; response=0x0000; timeout_err=1; resp_valid=1.
REQ-035 start pulsed at race 3 and again in DONE -> both ignored; after completion, one new start clears resp_valid and response on the next edge.
REQ-036 reset_n pulled low during race 9 -> all outputs take their reset values asynchronously with arb_reset=1; the next start produces a full, correct 16-bit response.
REQ-037 Race with arb_done and timeout landing on the same cycle -> out_s is captured and timeout_err stays 0.
